// File: rtl/rgb_frame_stats.sv
// Per-frame ROI statistics on the demosaiced RGB/Y pixel stream: sums, Y min/max and
// pixel count per frame, turned into 8-bit means by a sequential restoring divider.
module rgb_frame_stats #(
  parameter int SUM_W   = 28,
  parameter int CNT_W   = 20,
  parameter int COORD_W = 11
) (
  input  logic               VGA_CLK,
  input  logic               RST,
  input  logic               iVS,
  input  logic               iDVAL,
  input  logic [7:0]         iRed,
  input  logic [7:0]         iGreen,
  input  logic [7:0]         iBlue,
  input  logic [7:0]         iBW,
  input  logic [COORD_W-1:0] iROI_X0,
  input  logic [COORD_W-1:0] iROI_X1,
  input  logic [COORD_W-1:0] iROI_Y0,
  input  logic [COORD_W-1:0] iROI_Y1,
  output logic [7:0]         oMEAN_R,
  output logic [7:0]         oMEAN_G,
  output logic [7:0]         oMEAN_B,
  output logic [7:0]         oMEAN_Y,
  output logic [7:0]         oMIN_Y,
  output logic [7:0]         oMAX_Y,
  output logic [CNT_W-1:0]   oPIX_CNT,
  output logic               oSTAT_VALID,
  output logic               oBUSY
);

  localparam int BIT_W = $clog2(SUM_W);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_t;

  state_t             state, stateNext;
  logic               vsD, dvalD, seenLow;
  logic [COORD_W-1:0] xPos, yPos;
  logic [COORD_W-1:0] roiX0, roiX1, roiY0, roiY1;
  logic [SUM_W-1:0]   sumAcc [4];
  logic [CNT_W-1:0]   pixCnt;
  logic [7:0]         minY, maxY;
  logic [7:0]         meanReg [4];

  logic               divPrep;
  logic [SUM_W-1:0]   divDividend, divRem, divQuot;
  logic [BIT_W-1:0]   divBit;
  logic [1:0]         divChan;

  logic               frameStart, frameEnd, inRoi, divLast;
  logic [7:0]         pix [4];
  logic [SUM_W:0]     sumAdd [4];
  logic [SUM_W-1:0]   sumSat [4];
  logic [SUM_W:0]     remShift, remSub, divisor;
  logic               remFits;
  logic [SUM_W-1:0]   remNext, quotNext;
  logic [7:0]         quotSat;

  // A start edge only counts once iVS has been seen low, so a frame already in
  // progress when reset releases is never accumulated.
  assign frameStart = iVS & ~vsD & seenLow;
  assign frameEnd   = ~iVS & vsD;
  assign divLast    = (divBit == BIT_W'(SUM_W - 1));

  always_comb begin
    pix[0] = iRed;
    pix[1] = iGreen;
    pix[2] = iBlue;
    pix[3] = iBW;
    for (int i = 0; i < 4; i++) begin
      sumAdd[i] = {1'b0, sumAcc[i]} + (SUM_W + 1)'(pix[i]);
      sumSat[i] = sumAdd[i][SUM_W] ? '1 : sumAdd[i][SUM_W-1:0];
    end
    inRoi = (xPos >= roiX0) && (xPos <= roiX1) && (yPos >= roiY0) && (yPos <= roiY1);
  end

  // Restoring step: the borrow of the trial subtraction decides the quotient bit.
  always_comb begin
    divisor  = (SUM_W + 1)'(pixCnt);
    remShift = {divRem, divDividend[SUM_W-1]};
    remSub   = remShift - divisor;
    remFits  = ~remSub[SUM_W];
    remNext  = remFits ? remSub[SUM_W-1:0] : remShift[SUM_W-1:0];
    quotNext = {divQuot[SUM_W-2:0], remFits};
    quotSat  = (|quotNext[SUM_W-1:8]) ? 8'hFF : quotNext[7:0];
  end

  always_ff @(posedge VGA_CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= stateNext;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    oBUSY     = 1'b0;
    case (state)
      S_IDLE: if (frameStart) stateNext = S_ACC;
      S_ACC:  if (frameEnd) stateNext = S_DIV;
      S_DIV: begin
        oBUSY = 1'b1;
        if (!divPrep && divLast && (divChan == 2'd3)) stateNext = S_DONE;
      end
      S_DONE:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge VGA_CLK) begin
    if (RST) begin
      vsD         <= 1'b0;
      dvalD       <= 1'b0;
      seenLow     <= 1'b0;
      xPos        <= '0;
      yPos        <= '0;
      roiX0       <= '0;
      roiX1       <= '0;
      roiY0       <= '0;
      roiY1       <= '0;
      pixCnt      <= '0;
      minY        <= '0;
      maxY        <= '0;
      divPrep     <= 1'b0;
      divDividend <= '0;
      divRem      <= '0;
      divQuot     <= '0;
      divBit      <= '0;
      divChan     <= '0;
      oMEAN_R     <= '0;
      oMEAN_G     <= '0;
      oMEAN_B     <= '0;
      oMEAN_Y     <= '0;
      oMIN_Y      <= '0;
      oMAX_Y      <= '0;
      oPIX_CNT    <= '0;
      oSTAT_VALID <= 1'b0;
      // NOTE: these small arrays are plain flops, not RAM, so they are reset like any other state.
      for (int i = 0; i < 4; i++) begin
        sumAcc[i]  <= '0;
        meanReg[i] <= '0;
      end
    end else begin
      vsD         <= iVS;
      dvalD       <= iDVAL;
      oSTAT_VALID <= 1'b0;
      if (!iVS) seenLow <= 1'b1;

      case (state)
        S_IDLE: if (frameStart) begin
          for (int i = 0; i < 4; i++) sumAcc[i] <= '0;
          pixCnt <= '0;
          minY   <= 8'hFF;
          maxY   <= 8'h00;
          xPos   <= '0;
          yPos   <= '0;
          roiX0  <= iROI_X0;
          roiX1  <= iROI_X1;
          roiY0  <= iROI_Y0;
          roiY1  <= iROI_Y1;
        end

        S_ACC: begin
          if (frameEnd) begin
            divPrep <= 1'b1;
          end else if (iDVAL) begin
            if (inRoi) begin
              for (int i = 0; i < 4; i++) sumAcc[i] <= sumSat[i];
              if (!(&pixCnt)) pixCnt <= pixCnt + CNT_W'(1);
              if (iBW < minY) minY <= iBW;
              if (iBW > maxY) maxY <= iBW;
            end
            if (!(&xPos)) xPos <= xPos + COORD_W'(1);
          end else if (dvalD) begin
            xPos <= '0;
            if (!(&yPos)) yPos <= yPos + COORD_W'(1);
          end
        end

        S_DIV: begin
          if (divPrep) begin
            divPrep     <= 1'b0;
            divDividend <= sumAcc[0];
            divRem      <= '0;
            divQuot     <= '0;
            divBit      <= '0;
            divChan     <= 2'd0;
          end else if (divLast) begin
            meanReg[divChan] <= quotSat;
            if (divChan != 2'd3) begin
              divChan     <= divChan + 2'd1;
              divDividend <= sumAcc[divChan + 2'd1];
              divRem      <= '0;
              divQuot     <= '0;
              divBit      <= '0;
            end
          end else begin
            divDividend <= divDividend << 1;
            divRem      <= remNext;
            divQuot     <= quotNext;
            divBit      <= divBit + BIT_W'(1);
          end
        end

        S_DONE: begin
          oSTAT_VALID <= 1'b1;
          oPIX_CNT    <= pixCnt;
          if (pixCnt == '0) begin
            oMEAN_R <= '0;
            oMEAN_G <= '0;
            oMEAN_B <= '0;
            oMEAN_Y <= '0;
            oMIN_Y  <= '0;
            oMAX_Y  <= '0;
          end else begin
            oMEAN_R <= meanReg[0];
            oMEAN_G <= meanReg[1];
            oMEAN_B <= meanReg[2];
            oMEAN_Y <= meanReg[3];
            oMIN_Y  <= minY;
            oMAX_Y  <= maxY;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_frame_stats.sv
// Directed bench for rgb_frame_stats: hand-computed frame statistics, latency,
// empty ROI, skipped frame and reset recovery.
module tb_rgb_frame_stats;

  localparam int SUM_W   = 28;
  localparam int CNT_W   = 20;
  localparam int COORD_W = 11;
  localparam int LAT     = 4 * SUM_W + 2;

  logic               VGA_CLK = 1'b0;
  logic               RST;
  logic               iVS, iDVAL;
  logic [7:0]         iRed, iGreen, iBlue, iBW;
  logic [COORD_W-1:0] iROI_X0, iROI_X1, iROI_Y0, iROI_Y1;
  logic [7:0]         oMEAN_R, oMEAN_G, oMEAN_B, oMEAN_Y, oMIN_Y, oMAX_Y;
  logic [CNT_W-1:0]   oPIX_CNT;
  logic               oSTAT_VALID, oBUSY;

  int total = 0;
  int bad   = 0;

  rgb_frame_stats #(.SUM_W(SUM_W), .CNT_W(CNT_W), .COORD_W(COORD_W)) dut (
    .VGA_CLK(VGA_CLK), .RST(RST), .iVS(iVS), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iBW(iBW),
    .iROI_X0(iROI_X0), .iROI_X1(iROI_X1), .iROI_Y0(iROI_Y0), .iROI_Y1(iROI_Y1),
    .oMEAN_R(oMEAN_R), .oMEAN_G(oMEAN_G), .oMEAN_B(oMEAN_B), .oMEAN_Y(oMEAN_Y),
    .oMIN_Y(oMIN_Y), .oMAX_Y(oMAX_Y), .oPIX_CNT(oPIX_CNT),
    .oSTAT_VALID(oSTAT_VALID), .oBUSY(oBUSY)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic setRoi(input int x0, input int x1, input int y0, input int y1);
    iROI_X0 = COORD_W'(x0);
    iROI_X1 = COORD_W'(x1);
    iROI_Y0 = COORD_W'(y0);
    iROI_Y1 = COORD_W'(y1);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic startFrame();
    iVS = 1'b1;
    repeat (2) @(negedge VGA_CLK);
  endtask

  task automatic sendLineConst(input int n, input int r, input int g, input int b, input int y);
    for (int i = 0; i < n; i++) begin
      iDVAL = 1'b1; iRed = 8'(r); iGreen = 8'(g); iBlue = 8'(b); iBW = 8'(y);
      @(negedge VGA_CLK);
    end
    iDVAL = 1'b0;
    repeat (2) @(negedge VGA_CLK);
  endtask

  task automatic sendRampLine(input int n);
    for (int i = 0; i < n; i++) begin
      iDVAL = 1'b1; iRed = 8'(i * 30); iGreen = 8'd7; iBlue = 8'(255 - i * 10); iBW = 8'(i * 10);
      @(negedge VGA_CLK);
    end
    iDVAL = 1'b0;
    repeat (2) @(negedge VGA_CLK);
  endtask

  task automatic waitPulse(input string tag, input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge VGA_CLK);
      if (oSTAT_VALID) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Drops iVS and checks busy right after the end edge and the pulse latency.
  task automatic endFrameWait(input string tag);
    int lat;
    iVS = 1'b0;
    @(negedge VGA_CLK);
    check({tag, "_busy"}, 32'(oBUSY), 32'd1);
    waitPulse(tag, 400, lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic checkStats(input string tag, input int mr, input int mg, input int mb,
                            input int my, input int mn, input int mx, input int cnt);
    check({tag, "_meanR"}, 32'(oMEAN_R), 32'(mr));
    check({tag, "_meanG"}, 32'(oMEAN_G), 32'(mg));
    check({tag, "_meanB"}, 32'(oMEAN_B), 32'(mb));
    check({tag, "_meanY"}, 32'(oMEAN_Y), 32'(my));
    check({tag, "_minY"},  32'(oMIN_Y),  32'(mn));
    check({tag, "_maxY"},  32'(oMAX_Y),  32'(mx));
    check({tag, "_cnt"},   32'(oPIX_CNT), 32'(cnt));
    @(negedge VGA_CLK);
    check({tag, "_one_pulse"}, 32'(oSTAT_VALID), 32'd0);
    check({tag, "_idle"}, 32'(oBUSY), 32'd0);
  endtask

  task automatic waitNoPulse(input string tag, input int n);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge VGA_CLK);
      if (oSTAT_VALID) pulses++;
    end
    check({tag, "_no_pulse"}, 32'(pulses), 32'd0);
  endtask

  task automatic rstPulse();
    RST = 1'b1;
    @(negedge VGA_CLK);
    RST = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_meanR"}, 32'(oMEAN_R), 32'd0);
    check({tag, "_meanY"}, 32'(oMEAN_Y), 32'd0);
    check({tag, "_maxY"},  32'(oMAX_Y),  32'd0);
    check({tag, "_cnt"},   32'(oPIX_CNT), 32'd0);
    check({tag, "_valid"}, 32'(oSTAT_VALID), 32'd0);
    check({tag, "_busy"},  32'(oBUSY), 32'd0);
  endtask

  initial begin
    int lat;
    RST = 1'b1; iVS = 1'b0; iDVAL = 1'b0;
    iRed = '0; iGreen = '0; iBlue = '0; iBW = '0;
    setRoi(0, 639, 0, 479);
    repeat (3) @(negedge VGA_CLK);
    checkZero("reset");
    check("reset_minY", 32'(oMIN_Y), 32'd0);
    RST = 1'b0;
    @(negedge VGA_CLK);

    // 4x2 flat frame; the ROI is made empty after the start edge and must not matter.
    startFrame();
    setRoi(10, 5, 0, 479);
    sendLineConst(4, 100, 100, 100, 100);
    sendLineConst(4, 100, 100, 100, 100);
    endFrameWait("flat");
    checkStats("flat", 100, 100, 100, 100, 100, 100, 8);

    // 8x1 ramp, ROI columns 2..5: R 60..150, B 235..205, Y 20..50.
    setRoi(2, 5, 0, 0);
    startFrame();
    sendRampLine(8);
    endFrameWait("ramp");
    checkStats("ramp", 105, 7, 220, 35, 20, 50, 4);

    // Larger frame of saturated red, zero green, mid blue.
    setRoi(0, 639, 0, 479);
    startFrame();
    for (int l = 0; l < 64; l++) sendLineConst(320, 255, 0, 128, 50);
    endFrameWait("big");
    checkStats("big", 255, 0, 128, 50, 50, 50, 20480);

    // Inverted X range: empty ROI still produces a pulse with zeroed results.
    setRoi(10, 5, 0, 479);
    startFrame();
    sendLineConst(4, 77, 77, 77, 77);
    sendLineConst(4, 77, 77, 77, 77);
    endFrameWait("empty");
    checkStats("empty", 0, 0, 0, 0, 0, 0, 0);

    // Frame A, then frame B starting 20 cycles into the divide: B skipped, C accepted.
    setRoi(0, 639, 0, 479);
    startFrame();
    sendLineConst(4, 60, 60, 60, 60);
    sendLineConst(4, 60, 60, 60, 60);
    iVS = 1'b0;
    repeat (20) @(negedge VGA_CLK);
    iVS = 1'b1;
    sendLineConst(4, 200, 200, 200, 200);
    sendLineConst(4, 200, 200, 200, 200);
    waitPulse("frameA", 300, lat);
    check("frameA_meanY", 32'(oMEAN_Y), 32'd60);
    check("frameA_cnt", 32'(oPIX_CNT), 32'd8);
    iVS = 1'b0;
    waitNoPulse("frameB", 300);
    startFrame();
    sendLineConst(4, 30, 30, 30, 30);
    sendLineConst(4, 30, 30, 30, 30);
    endFrameWait("frameC");
    checkStats("frameC", 30, 30, 30, 30, 30, 30, 8);

    // Reset in the middle of accumulation; the rest of that frame is ignored.
    startFrame();
    sendLineConst(4, 90, 90, 90, 90);
    rstPulse();
    checkZero("rst_acc");
    sendLineConst(4, 90, 90, 90, 90);
    iVS = 1'b0;
    waitNoPulse("rst_acc", 300);

    // Reset in the middle of the divide.
    startFrame();
    sendLineConst(4, 40, 40, 40, 40);
    iVS = 1'b0;
    repeat (20) @(negedge VGA_CLK);
    check("rst_div_busy_before", 32'(oBUSY), 32'd1);
    rstPulse();
    checkZero("rst_div");
    waitNoPulse("rst_div", 300);

    startFrame();
    sendLineConst(4, 90, 90, 90, 90);
    sendLineConst(4, 90, 90, 90, 90);
    endFrameWait("recover");
    checkStats("recover", 90, 90, 90, 90, 90, 90, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
